// File: rtl/pci_reset_sequencer.sv
// PCI reset sequencer: synchronizes pad reset and PLL lock, drives RST#
// in host mode, and releases a registered core reset once the clock is stable.
module pci_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int RST_ASSERT_CYCLES   = 33000,
  parameter int RST_RECOVERY_CYCLES = 16
) (
  input  logic       pci_clk,
  input  logic       pci_reset_l,
  input  logic       pci_reset_raw,
  input  logic       pll_locked,
  input  logic       pci_pll_bypass,
  input  logic       host_mode,
  input  logic       host_reset_req,
  output logic       pci_reset_out_oe_comb,
  output logic       core_reset,
  output logic       reset_done,
  output logic [2:0] seq_state
);

  localparam logic [2:0] HOLD         = 3'd0;
  localparam logic [2:0] WAIT_LOCK    = 3'd1;
  localparam logic [2:0] RECOVER      = 3'd2;
  localparam logic [2:0] RUN          = 3'd3;
  localparam logic [2:0] DRIVE        = 3'd4;
  localparam logic [2:0] WAIT_RELEASE = 3'd5;

  localparam logic [15:0] REC_LAST = 16'(RST_RECOVERY_CYCLES - 1);
  localparam logic [15:0] DRV_LAST = 16'(RST_ASSERT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_s;
  logic                   lock_ok;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic core_reset_q, core_reset_d;
  logic oe_q, oe_d;
  logic done_q, done_d;

  // Two-flop style synchronizers; reset sits asserted, lock sits unlocked
  always_ff @(posedge pci_clk) begin
    if (!pci_reset_l) begin
      rst_sync_q  <= '1;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], pci_reset_raw};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign rst_s   = rst_sync_q[SYNC_STAGES-1];
  assign lock_ok = lock_sync_q[SYNC_STAGES-1] | pci_pll_bypass;

  // State and shared counter register
  always_ff @(posedge pci_clk) begin
    if (!pci_reset_l) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; DRIVE runs to completion regardless of inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (!rst_s) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (rst_s) begin
          state_d = HOLD;
        end else if (lock_ok) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        if (rst_s)              state_d = HOLD;
        else if (!lock_ok)      state_d = WAIT_LOCK;
        else if (cnt_q == REC_LAST) state_d = RUN;
        else                    cnt_d = cnt_q + 16'd1;
      end
      RUN: begin
        if (rst_s) begin
          state_d = HOLD;
        end else if (!lock_ok) begin
          state_d = WAIT_LOCK;
        end else if (host_mode && host_reset_req) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRV_LAST) state_d = WAIT_RELEASE;
        else                   cnt_d = cnt_q + 16'd1;
      end
      WAIT_RELEASE: begin
        if (!rst_s) state_d = WAIT_LOCK;
      end
      default: state_d = HOLD;
    endcase
  end

  // Output decode from the next state so outputs register in step with it
  always_comb begin
    core_reset_d = (state_d != RUN);
    oe_d         = (state_d == DRIVE);
    done_d       = (state_q == RECOVER) && (state_d == RUN);
  end

  // Output registers
  always_ff @(posedge pci_clk) begin
    if (!pci_reset_l) begin
      core_reset_q <= 1'b1;
      oe_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      core_reset_q <= core_reset_d;
      oe_q         <= oe_d;
      done_q       <= done_d;
    end
  end

  assign core_reset            = core_reset_q;
  assign pci_reset_out_oe_comb = oe_q;
  assign reset_done            = done_q;
  assign seq_state             = state_q;

endmodule
